multicycle_control: RTL

- Control FSM that sequences a multi-cycle LEGv8 datapath. It replaces the single-cycle combinational control with a staged sequence: FETCH, DECODE, EXEC, MEM, WB.
- Inputs are the latched IR opcode, the ALU zero flag and a data-memory ready handshake.
- Outputs are per-state datapath strobes and selects, so one ALU and one memory port are shared across the stages of each instruction.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_opcode_decode.sv | 28 ++
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle LEGv8 control FSM.
// Holds the opcode patterns and masks, the ALU and sign-extend selects, and the error codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_MOVZ = 3'd2,
    C_LDUR = 3'd3,
    C_STUR = 3'd4,
    C_CBZ  = 3'd5,
    C_B    = 3'd6,
    C_ILL  = 3'd7
  } class_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILL     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_MOVZ = 11'b11010010100;

  // A set mask bit means the opcode bit must match the pattern.
  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] MASK_MOVZ = 11'b11111111100;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [2:0] SIGN_I    = 3'b000;
  localparam logic [2:0] SIGN_D    = 3'b001;
  localparam logic [2:0] SIGN_B    = 3'b010;
  localparam logic [2:0] SIGN_CB   = 3'b011;
  localparam logic [2:0] SIGN_MOVZ = 3'b100;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == (pat & mask);
  endfunction

  function automatic logic [3:0] r_alu_op(input logic [10:0] op);
    logic [3:0] res;
    res = ALU_ADD;
    if (op == OP_SUB) res = ALU_SUB;
    else if (op == OP_AND) res = ALU_AND;
    else if (op == OP_ORR) res = ALU_ORR;
    return res;
  endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: IR[31:21] to instruction class; no latency, no flow control.
// Anything that does not match a supported pattern classifies as C_ILL.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output class_t      op_class
);

  always_comb begin
    op_class = C_ILL;
    if (op_match(opcode, OP_ADD, MASK_FULL) || op_match(opcode, OP_SUB, MASK_FULL) ||
        op_match(opcode, OP_AND, MASK_FULL) || op_match(opcode, OP_ORR, MASK_FULL)) begin
      op_class = C_R;
    end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
      op_class = C_LDUR;
    end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
      op_class = C_STUR;
    end else if (op_match(opcode, OP_CBZ, MASK_CBZ)) begin
      op_class = C_CBZ;
    end else if (op_match(opcode, OP_B, MASK_B)) begin
      op_class = C_B;
    end else if (op_match(opcode, OP_MOVZ, MASK_MOVZ)) begin
      op_class = C_MOVZ;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB, stalls in MEM on mem_ready, halts on illegal op or timeout.
// Optional MC_PERF_CNT_EN adds cycle_cnt and retired_cnt performance counters.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        reg2loc,
  output logic        alu_src,
  output logic [3:0]  alu_op,
  output logic [2:0]  sign_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        instr_done,
  output logic [2:0]  state,
  output logic [1:0]  err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  class_t     class_q, dec_class;
  logic [3:0] r_op_q;
  logic [1:0] err_q;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       ir_w, pc_w, reg_w, mem_rd, mem_wr;

  mc_opcode_decode u_decode (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_FETCH;
      class_q  <= C_NONE;
      r_op_q   <= ALU_AND;
      err_q    <= ERR_NONE;
      wait_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        class_q <= dec_class;
        r_op_q  <= r_alu_op(opcode);
        if (dec_class == C_ILL) err_q <= ERR_ILL;
      end
      if (timeout) err_q <= ERR_TIMEOUT;
      // Held at zero outside MEM so every access starts its own count.
      if (state_q != S_MEM) begin
        wait_cnt <= 8'd0;
      end else if (!mem_ready && (wait_cnt < WAIT_LIMIT)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ir_w    = 1'b0;
    pc_w    = 1'b0;
    pc_src  = 1'b0;
    reg_w   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_w    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (dec_class == C_ILL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (class_q)
          C_R, C_MOVZ:    state_d = S_WB;
          C_LDUR, C_STUR: state_d = S_MEM;
          C_CBZ: begin
            pc_w    = 1'b1;
            pc_src  = zero;
            state_d = S_FETCH;
          end
          C_B: begin
            pc_w    = 1'b1;
            pc_src  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // A ready on the limit cycle still completes the access.
        if (mem_ready) begin
          mem_rd = (class_q == C_LDUR);
          mem_wr = (class_q == C_STUR);
          if (class_q == C_STUR) begin
            pc_w    = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt >= WAIT_LIMIT) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end else begin
          mem_rd = (class_q == C_LDUR);
          mem_wr = (class_q == C_STUR);
        end
      end
      S_WB: begin
        reg_w   = 1'b1;
        pc_w    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked during reset so an in-flight access is abandoned.
  assign ir_write   = ir_w   & ~reset;
  assign pc_write   = pc_w   & ~reset;
  assign reg_write  = reg_w  & ~reset;
  assign mem_read   = mem_rd & ~reset;
  assign mem_write  = mem_wr & ~reset;
  assign instr_done = pc_write;
  assign state      = state_q;
  assign err        = err_q;

  always_comb begin
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_AND;
    sign_op    = SIGN_I;
    mem_to_reg = 1'b0;
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      case (class_q)
        C_R: alu_op = r_op_q;
        C_MOVZ: begin
          alu_src = 1'b1;
          alu_op  = ALU_PASSB;
          sign_op = SIGN_MOVZ;
        end
        C_LDUR: begin
          alu_src    = 1'b1;
          alu_op     = ALU_ADD;
          sign_op    = SIGN_D;
          mem_to_reg = 1'b1;
        end
        C_STUR: begin
          reg2loc = 1'b1;
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
          sign_op = SIGN_D;
        end
        C_CBZ: begin
          reg2loc = 1'b1;
          alu_op  = ALU_PASSB;
          sign_op = SIGN_CB;
        end
        C_B:     sign_op = SIGN_B;
        default: alu_op = ALU_AND;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      if (state_q != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule
